// File: rtl/w5300_socket_n_bus_responder.sv
// W5300 host-bus slave emulating one Socket N register block (UDP subset).
// RX words are injected and TX words observed through side ports for loopback bring-up.
module w5300_socket_n_bus_responder #(
    parameter int unsigned N        = 0,
    parameter int unsigned TX_BYTES = 8192,
    parameter int unsigned RX_WORDS = 16,
    parameter int unsigned CMD_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  addr,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdata_oe,
    output logic        int_n,
    input  logic        rx_inj_valid,
    output logic        rx_inj_ready,
    input  logic [15:0] rx_inj_data,
    output logic        tx_mon_valid,
    output logic [15:0] tx_mon_data,
    output logic        tx_sent,
    output logic [16:0] tx_sent_bytes,
    output logic        ovf_err
);

    localparam int unsigned SW = 17;
    localparam int unsigned PW = (RX_WORDS > 1) ? $clog2(RX_WORDS) : 1;
    localparam int unsigned CW = $clog2(RX_WORDS + 1);
    localparam int unsigned LW = (CMD_LAT > 1) ? $clog2(CMD_LAT) : 1;
    localparam logic [9:0]  BASE = 10'(32'h200 + 32'h040 * N);

    localparam logic [5:0] OFF_MR     = 6'h00;
    localparam logic [5:0] OFF_CR     = 6'h02;
    localparam logic [5:0] OFF_IMR    = 6'h04;
    localparam logic [5:0] OFF_IR     = 6'h06;
    localparam logic [5:0] OFF_SSR    = 6'h08;
    localparam logic [5:0] OFF_PORTR  = 6'h0A;
    localparam logic [5:0] OFF_DPORTR = 6'h12;
    localparam logic [5:0] OFF_DIPR0  = 6'h14;
    localparam logic [5:0] OFF_DIPR2  = 6'h16;
    localparam logic [5:0] OFF_MSSR   = 6'h18;
    localparam logic [5:0] OFF_WRSR0  = 6'h20;
    localparam logic [5:0] OFF_WRSR2  = 6'h22;
    localparam logic [5:0] OFF_FSR0   = 6'h24;
    localparam logic [5:0] OFF_FSR2   = 6'h26;
    localparam logic [5:0] OFF_RSR0   = 6'h28;
    localparam logic [5:0] OFF_RSR2   = 6'h2A;
    localparam logic [5:0] OFF_TXF    = 6'h2E;
    localparam logic [5:0] OFF_RXF    = 6'h30;

    localparam logic [15:0] CMD_OPEN  = 16'h0001;
    localparam logic [15:0] CMD_CLOSE = 16'h0010;
    localparam logic [15:0] CMD_SEND  = 16'h0020;
    localparam logic [15:0] CMD_RECV  = 16'h0040;
    localparam logic [7:0]  SSR_UDP   = 8'h22;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e          state_q;
    logic [LW-1:0]   lat_q;
    logic [15:0]     cmd_q;
    logic            wr_n_q, rd_n_q;

    logic [15:0]     mr_q, mr_d, imr_q, imr_d, ir_q, ir_d;
    logic [15:0]     portr_q, portr_d, dportr_q, dportr_d;
    logic [15:0]     dipr0_q, dipr0_d, dipr2_q, dipr2_d, mssr_q, mssr_d;
    logic [7:0]      ssr_q, ssr_d;
    logic [SW-1:0]   wrsr_q, wrsr_d, fsr_q, fsr_d, rsr_q, rsr_d;
    logic [SW-1:0]   pend_q, pend_d, popped_q, popped_d;
    logic [15:0]     fifo_mem [RX_WORDS];
    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pop_arm_q, pop_arm_d;
    logic            ready_q, ready_d, int_n_q, int_n_d, ovf_q, ovf_d;
    logic            txv_q, txv_d, sent_q, sent_d, oe_q, oe_d;
    logic [15:0]     txd_q, txd_d, rdata_q, rdata_d, rd_mux;
    logic [SW-1:0]   sent_bytes_q, sent_bytes_d;

    logic [5:0] off;
    logic       hit, wr_commit, rd_act, rd_fall, rd_rise;
    logic       done, ssr_udp, do_open, do_close, do_send, do_recv;
    logic       inj_ok, pop, tx_wr;

    assign off       = addr[5:0];
    assign hit       = !cs_n && (addr[9:6] == BASE[9:6]);
    assign wr_commit = hit && wr_n && !wr_n_q;
    assign rd_act    = hit && !rd_n;
    assign rd_fall   = rd_act && rd_n_q;
    assign rd_rise   = rd_n && !rd_n_q;

    assign done      = (state_q == ST_DONE);
    assign ssr_udp   = (ssr_q == SSR_UDP);
    assign do_open   = done && (cmd_q == CMD_OPEN);
    assign do_close  = done && (cmd_q == CMD_CLOSE);
    assign do_send   = done && (cmd_q == CMD_SEND) && ssr_udp;
    assign do_recv   = done && (cmd_q == CMD_RECV) && ssr_udp;
    assign inj_ok    = rx_inj_valid && ready_q && ssr_udp && !do_close;
    assign pop       = rd_rise && pop_arm_q && (cnt_q != '0);
    assign tx_wr     = wr_commit && (off == OFF_TXF);

    // Command sequencer: a command sits in CR for CMD_LAT cycles, then takes effect in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            cmd_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (wr_commit && off == OFF_CR && wdata != 16'h0000) begin
                    state_q <= ST_BUSY;
                    cmd_q   <= wdata;
                    lat_q   <= '0;
                end
                ST_BUSY: begin
                    if (lat_q == LW'(CMD_LAT - 1)) state_q <= ST_DONE;
                    else                           lat_q   <= lat_q + LW'(1);
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (off)
            OFF_MR:     rd_mux = mr_q;
            OFF_CR:     rd_mux = (state_q == ST_BUSY) ? cmd_q : 16'h0000;
            OFF_IMR:    rd_mux = imr_q;
            OFF_IR:     rd_mux = ir_q;
            OFF_SSR:    rd_mux = {8'h00, ssr_q};
            OFF_PORTR:  rd_mux = portr_q;
            OFF_DPORTR: rd_mux = dportr_q;
            OFF_DIPR0:  rd_mux = dipr0_q;
            OFF_DIPR2:  rd_mux = dipr2_q;
            OFF_MSSR:   rd_mux = mssr_q;
            OFF_WRSR0:  rd_mux = {15'h0000, wrsr_q[16]};
            OFF_WRSR2:  rd_mux = wrsr_q[15:0];
            OFF_FSR0:   rd_mux = {15'h0000, fsr_q[16]};
            OFF_FSR2:   rd_mux = fsr_q[15:0];
            OFF_RSR0:   rd_mux = {15'h0000, rsr_q[16]};
            OFF_RSR2:   rd_mux = rsr_q[15:0];
            OFF_RXF:    rd_mux = (cnt_q != '0) ? fifo_mem[rp_q] : 16'h0000;
            default:    rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        mr_d = mr_q;   imr_d = imr_q;   portr_d = portr_q;   dportr_d = dportr_q;
        dipr0_d = dipr0_q;   dipr2_d = dipr2_q;   mssr_d = mssr_q;   ssr_d = ssr_q;
        wrsr_d = wrsr_q;   fsr_d = fsr_q;   pend_d = pend_q;
        wp_d = wp_q;   rp_d = rp_q;   cnt_d = cnt_q;   pop_arm_d = pop_arm_q;
        ovf_d = ovf_q;   txv_d = 1'b0;   txd_d = txd_q;
        sent_d = 1'b0;   sent_bytes_d = sent_bytes_q;
        rdata_d = rd_act ? rd_mux : 16'h0000;
        oe_d    = rd_act;

        if (wr_commit) begin
            case (off)
                OFF_MR:     mr_d            = wdata;
                OFF_IMR:    imr_d           = wdata;
                OFF_PORTR:  portr_d         = wdata;
                OFF_DPORTR: dportr_d        = wdata;
                OFF_DIPR0:  dipr0_d         = wdata;
                OFF_DIPR2:  dipr2_d         = wdata;
                OFF_MSSR:   mssr_d          = wdata;
                OFF_WRSR0:  wrsr_d[16]      = wdata[0];
                OFF_WRSR2:  wrsr_d[15:0]    = wdata;
                default: ;
            endcase
        end

        // Interrupt set has priority over a coincident write-one-to-clear
        ir_d = (ir_q & ~((wr_commit && off == OFF_IR) ? wdata : 16'h0000))
             | {7'h00, do_send, 1'b0, inj_ok, 6'h00};

        if (do_open && mr_q[3:0] == 4'h2) ssr_d = SSR_UDP;
        if (do_close)                     ssr_d = 8'h00;

        if (do_send) begin
            sent_d       = 1'b1;
            sent_bytes_d = wrsr_q;
            if (wrsr_q > pend_q) ovf_d = 1'b1;
        end
        if (do_send || do_close) begin
            pend_d = '0;
            fsr_d  = SW'(TX_BYTES);
        end
        if (tx_wr) begin
            if (fsr_d >= SW'(2)) begin
                txv_d  = 1'b1;
                txd_d  = wdata;
                pend_d = pend_d + SW'(2);
                fsr_d  = fsr_d - SW'(2);
            end else begin
                ovf_d  = 1'b1;
            end
        end

        if (rd_fall)      pop_arm_d = (off == OFF_RXF) && (cnt_q != '0);
        else if (rd_rise) pop_arm_d = 1'b0;

        if (inj_ok) wp_d = wp_q + PW'(1);
        if (pop)    rp_d = rp_q + PW'(1);
        case ({inj_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // RSR only shrinks on RECV, by the bytes the host has popped since the previous RECV
        rsr_d    = rsr_q + (inj_ok ? SW'(2) : SW'(0)) - (do_recv ? popped_q : SW'(0));
        popped_d = (do_recv ? SW'(0) : popped_q) + (pop ? SW'(2) : SW'(0));

        if (do_close) begin
            wp_d = '0;   rp_d = '0;   cnt_d = '0;
            rsr_d = '0;   popped_d = '0;   pop_arm_d = 1'b0;
        end

        ready_d = (cnt_d != CW'(RX_WORDS));
        int_n_d = ~|(ir_d & imr_d);
    end

    always_ff @(posedge clk) begin
        if (inj_ok) fifo_mem[wp_q] <= rx_inj_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_q <= 1'b1;   rd_n_q <= 1'b1;
            mr_q <= '0;   imr_q <= '0;   ir_q <= '0;   ssr_q <= '0;
            portr_q <= '0;   dportr_q <= '0;   dipr0_q <= '0;   dipr2_q <= '0;   mssr_q <= '0;
            wrsr_q <= '0;   fsr_q <= SW'(TX_BYTES);   rsr_q <= '0;
            pend_q <= '0;   popped_q <= '0;
            wp_q <= '0;   rp_q <= '0;   cnt_q <= '0;   pop_arm_q <= 1'b0;
            ready_q <= 1'b1;   int_n_q <= 1'b1;   ovf_q <= 1'b0;
            txv_q <= 1'b0;   txd_q <= '0;   sent_q <= 1'b0;   sent_bytes_q <= '0;
            rdata_q <= '0;   oe_q <= 1'b0;
        end else begin
            wr_n_q <= wr_n;   rd_n_q <= rd_n;
            mr_q <= mr_d;   imr_q <= imr_d;   ir_q <= ir_d;   ssr_q <= ssr_d;
            portr_q <= portr_d;   dportr_q <= dportr_d;
            dipr0_q <= dipr0_d;   dipr2_q <= dipr2_d;   mssr_q <= mssr_d;
            wrsr_q <= wrsr_d;   fsr_q <= fsr_d;   rsr_q <= rsr_d;
            pend_q <= pend_d;   popped_q <= popped_d;
            wp_q <= wp_d;   rp_q <= rp_d;   cnt_q <= cnt_d;   pop_arm_q <= pop_arm_d;
            ready_q <= ready_d;   int_n_q <= int_n_d;   ovf_q <= ovf_d;
            txv_q <= txv_d;   txd_q <= txd_d;   sent_q <= sent_d;   sent_bytes_q <= sent_bytes_d;
            rdata_q <= rdata_d;   oe_q <= oe_d;
        end
    end

    assign rdata         = rdata_q;
    assign rdata_oe      = oe_q;
    assign int_n         = int_n_q;
    assign rx_inj_ready  = ready_q;
    assign tx_mon_valid  = txv_q;
    assign tx_mon_data   = txd_q;
    assign tx_sent       = sent_q;
    assign tx_sent_bytes = sent_bytes_q;
    assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_w5300_socket_n_bus_responder.sv
// Scoreboard bench for the Socket N responder: a register-level reference model
// predicts read data, TX monitor words and SEND byte counts; a monitor compares them.
module tb_w5300_socket_n_bus_responder;

    localparam int unsigned TXB = 8192;
    localparam int unsigned RXW = 16;
    localparam int unsigned LAT = 4;
    localparam logic [9:0]  BASE = 10'h200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  addr = '0;
    logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        rdata_oe, int_n;
    logic        rx_inj_valid = 1'b0;
    logic        rx_inj_ready;
    logic [15:0] rx_inj_data = '0;
    logic        tx_mon_valid;
    logic [15:0] tx_mon_data;
    logic        tx_sent;
    logic [16:0] tx_sent_bytes;
    logic        ovf_err;

    w5300_socket_n_bus_responder #(.N(0), .TX_BYTES(TXB), .RX_WORDS(RXW), .CMD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe), .int_n(int_n),
        .rx_inj_valid(rx_inj_valid), .rx_inj_ready(rx_inj_ready), .rx_inj_data(rx_inj_data),
        .tx_mon_valid(tx_mon_valid), .tx_mon_data(tx_mon_data), .tx_sent(tx_sent),
        .tx_sent_bytes(tx_sent_bytes), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model state
    int          m_rw [64];
    int          m_ir, m_ssr, m_fsr, m_rsr, m_pend, m_popped, m_wrsr, m_cr;
    bit          m_ovf;
    logic [15:0] m_fifo [$];

    logic [15:0] q_rd [$];
    string       q_rd_n [$];
    logic [15:0] q_tx [$];
    int          q_sent [$];

    function automatic void model_reset();
        foreach (m_rw[i]) m_rw[i] = 0;
        m_ir = 0; m_ssr = 0; m_fsr = TXB; m_rsr = 0; m_pend = 0; m_popped = 0;
        m_wrsr = 0; m_cr = 0; m_ovf = 0;
        m_fifo.delete();
    endfunction

    function automatic bit is_rw(int off);
        return off == 'h00 || off == 'h04 || off == 'h0A || off == 'h12 ||
               off == 'h14 || off == 'h16 || off == 'h18;
    endfunction

    function automatic int exp_reg(int off);
        case (off)
            'h02: return m_cr;
            'h06: return m_ir;
            'h08: return m_ssr;
            'h20: return (m_wrsr >> 16) & 1;
            'h22: return m_wrsr & 'hFFFF;
            'h24: return (m_fsr >> 16) & 1;
            'h26: return m_fsr & 'hFFFF;
            'h28: return (m_rsr >> 16) & 1;
            'h2A: return m_rsr & 'hFFFF;
            'h30: return (m_fifo.size() > 0) ? int'(m_fifo[0]) : 0;
            default: return is_rw(off) ? m_rw[off] : 0;
        endcase
    endfunction

    function automatic void apply_cmd(int cmd);
        if (cmd == 'h01 && (m_rw['h00] & 'hF) == 2) m_ssr = 'h22;
        else if (cmd == 'h10) begin
            m_ssr = 0; m_fifo.delete(); m_pend = 0; m_fsr = TXB; m_rsr = 0; m_popped = 0;
        end else if (cmd == 'h20 && m_ssr == 'h22) begin
            if (m_wrsr > m_pend) m_ovf = 1;
            m_pend = 0; m_fsr = TXB; m_ir |= 'h100;
        end else if (cmd == 'h40 && m_ssr == 'h22) begin
            m_rsr -= m_popped; m_popped = 0;
        end
    endfunction

    task automatic bus_wr(input logic [9:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        addr = a; wdata = d; cs_n = 1'b0; wr_n = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1;
        @(posedge clk); #1;
        cs_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [9:0] a, input bit outside);
        @(posedge clk); #1;
        addr = a; cs_n = 1'b0; rd_n = 1'b0;
        @(posedge clk); #1;
        if (outside) check("outside_read_oe", 32'(rdata_oe), 32'd0);
        @(posedge clk); #1;
        rd_n = 1'b1;
        @(posedge clk); #1;
        cs_n = 1'b1;
    endtask

    task automatic wr(input int off, input logic [15:0] d);
        if (is_rw(off)) m_rw[off] = int'(d);
        else if (off == 'h06) m_ir &= ~int'(d);
        else if (off == 'h20) m_wrsr = (m_wrsr & 'hFFFF) | (int'(d[0]) << 16);
        else if (off == 'h22) m_wrsr = (m_wrsr & 'h10000) | int'(d);
        else if (off == 'h2E) begin
            if (m_fsr >= 2) begin
                q_tx.push_back(d); m_pend += 2; m_fsr -= 2;
            end else m_ovf = 1;
        end
        bus_wr(BASE + 10'(off), d);
    endtask

    task automatic rd(input int off, input string nm);
        q_rd.push_back(16'(exp_reg(off)));
        q_rd_n.push_back(nm);
        bus_rd(BASE + 10'(off), 1'b0);
        if (off == 'h30 && m_fifo.size() > 0) begin
            void'(m_fifo.pop_front());
            m_popped += 2;
        end
    endtask

    task automatic cmd(input int c, input bit watch_cr);
        if (c == 'h20 && m_ssr == 'h22) q_sent.push_back(m_wrsr);
        bus_wr(BASE + 10'h002, 16'(c));
        if (watch_cr) begin
            m_cr = c;
            rd('h02, "cr_busy");
        end
        repeat (LAT + 2) @(posedge clk);
        #1;
        m_cr = 0;
        apply_cmd(c);
        if (watch_cr) rd('h02, "cr_idle");
    endtask

    task automatic inject(input logic [15:0] d);
        @(posedge clk); #1;
        check("rx_inj_ready", 32'(rx_inj_ready), 32'(m_fifo.size() < RXW));
        rx_inj_valid = 1'b1; rx_inj_data = d;
        @(posedge clk); #1;
        rx_inj_valid = 1'b0;
        if (m_fifo.size() < RXW && m_ssr == 'h22) begin
            m_fifo.push_back(d); m_rsr += 2; m_ir |= 'h40;
        end
    endtask

    task automatic check_int();
        check("int_n", 32'(int_n), 32'((m_ir & m_rw['h04]) == 0));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, TX word or SEND
    logic oe_prev = 1'b0;
    always @(negedge clk) begin
        if (rdata_oe && !oe_prev) begin
            if (q_rd.size() == 0) check("unexpected_read_oe", 32'd1, 32'd0);
            else check(q_rd_n.pop_front(), 32'(rdata), 32'(q_rd.pop_front()));
        end
        oe_prev = rdata_oe;
        if (tx_mon_valid) begin
            if (q_tx.size() == 0) check("unexpected_tx_mon", 32'd1, 32'd0);
            else check("tx_mon_data", 32'(tx_mon_data), 32'(q_tx.pop_front()));
        end
        if (tx_sent) begin
            if (q_sent.size() == 0) check("unexpected_tx_sent", 32'd1, 32'd0);
            else check("tx_sent_bytes", 32'(tx_sent_bytes), 32'(q_sent.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, j;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("reset_int_n", 32'(int_n), 32'd1);
        check("reset_rx_ready", 32'(rx_inj_ready), 32'd1);
        check("reset_ovf", 32'(ovf_err), 32'd0);
        rd('h08, "reset_ssr");
        rd('h24, "reset_fsr0");
        rd('h26, "reset_fsr2");

        // Random RW registers, unmapped address, outside-block isolation
        foreach (m_rw[i]) if (is_rw(i) && i != 0) begin
            wr(i, 16'($urandom));
            rd(i, "rw_readback");
        end
        rd('h0C, "unmapped_read");
        wr('h0C, 16'hBEEF);
        rd('h0C, "unmapped_after_write");
        wr('h00, 16'h0002);
        bus_wr(10'h240, 16'hFFFF);
        bus_rd(10'h240, 1'b1);
        rd('h00, "mr_after_outside_write");

        // OPEN in UDP mode
        wr('h04, 16'h0140);
        cmd('h01, 1'b1);
        rd('h08, "ssr_udp");
        check_int();

        // TX: three words then SEND
        for (int i = 0; i < 3; i++) wr('h2E, 16'($urandom));
        rd('h26, "fsr2_after_tx");
        wr('h22, 16'd6);
        cmd('h20, 1'b0);
        rd('h26, "fsr2_after_send");
        rd('h06, "ir_sendok");
        check_int();
        wr('h06, 16'h0100);
        check_int();
        check("ovf_after_send", 32'(ovf_err), 32'(m_ovf));

        // RX: fixed pattern, then RECV
        inject(16'hA5A5);
        inject(16'h5A5A);
        check_int();
        rd('h2A, "rsr2_two_words");
        rd('h30, "rx_word0");
        rd('h30, "rx_word1");
        cmd('h40, 1'b0);
        rd('h2A, "rsr2_after_recv");
        wr('h06, 16'h0040);
        check_int();

        // Randomized TX/RX rounds
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 8);
            for (int i = 0; i < k; i++) wr('h2E, 16'($urandom));
            wr('h20, 16'h0000);
            wr('h22, 16'(2 * k));
            cmd('h20, 1'b0);
            k = $urandom_range(1, 6);
            j = $urandom_range(0, k);
            for (int i = 0; i < k; i++) inject(16'($urandom));
            rd('h2A, "rsr2_round");
            for (int i = 0; i < j; i++) rd('h30, "rx_round_word");
            cmd('h40, 1'b0);
            rd('h2A, "rsr2_round_recv");
            for (int i = j; i < k; i++) rd('h30, "rx_round_rest");
            cmd('h40, 1'b0);
            rd('h28, "rsr0_round");
            wr('h06, 16'h0140);
        end

        // RX FIFO full: 17th injection refused, drain, empty read
        for (int i = 0; i < RXW + 1; i++) inject(16'($urandom));
        check("rx_ready_full", 32'(rx_inj_ready), 32'd0);
        rd('h2A, "rsr2_full");
        for (int i = 0; i < RXW; i++) rd('h30, "rx_full_drain");
        rd('h30, "rx_empty_read");
        cmd('h40, 1'b0);
        rd('h2A, "rsr2_drained");
        wr('h06, 16'h0040);

        // TX buffer exhaustion: last write dropped and flagged
        for (int i = 0; i < TXB / 2 + 1; i++) wr('h2E, 16'($urandom));
        rd('h26, "fsr2_exhausted");
        check("ovf_tx_full", 32'(ovf_err), 32'(m_ovf));
        cmd('h10, 1'b0);
        rd('h08, "ssr_closed");
        rd('h26, "fsr2_after_close");

        // Non-UDP OPEN, ignored SEND, reset during BUSY
        wr('h00, 16'h0001);
        cmd('h01, 1'b0);
        rd('h08, "ssr_mr1_open");
        wr('h22, 16'd4);
        cmd('h20, 1'b0);
        bus_wr(BASE + 10'h002, 16'h0001);
        @(posedge clk); #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd('h02, "cr_after_reset");
        rd('h08, "ssr_after_reset");
        rd('h26, "fsr2_after_reset");
        check("int_n_after_reset", 32'(int_n), 32'd1);
        check("ovf_after_reset", 32'(ovf_err), 32'd0);

        repeat (4) @(posedge clk);
        check("rd_queue_drained", 32'(q_rd.size()), 32'd0);
        check("tx_queue_drained", 32'(q_tx.size()), 32'd0);
        check("sent_queue_drained", 32'(q_sent.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
